// File: rtl/cyclo_downconvert_mult.sv
// FAM channelizer downconversion: multiplies each FFT sample X(p,m) by its LUT phase coefficient.
// Four register stages (capture, products, sums, round/saturate) with sample/block tracking and framing check.
module cyclo_downconvert_mult #(
  parameter int P       = 1024,
  parameter int NP      = 1024,
  parameter int NB_DATA = 16,
  parameter int NB_EXP  = 10,
  parameter int NB_OUT  = 16,
  localparam int MW = (NP > 1) ? $clog2(NP) : 1,
  localparam int PW = (P > 1) ? $clog2(P) : 1
) (
  input  logic                      clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic signed [NB_DATA-1:0] i_fft_real,
  input  logic signed [NB_DATA-1:0] i_fft_imag,
  input  logic                      i_fft_tvalid,
  input  logic                      i_fft_tlast,
  input  logic signed [NB_EXP-1:0]  i_exp_real,
  input  logic signed [NB_EXP-1:0]  i_exp_imag,
  output logic signed [NB_OUT-1:0]  o_prod_real,
  output logic signed [NB_OUT-1:0]  o_prod_imag,
  output logic                      o_tvalid,
  output logic                      o_tlast,
  output logic [MW-1:0]             o_sample_idx,
  output logic [PW-1:0]             o_block_idx,
  output logic                      o_frame_err,
  output logic                      o_sat
);

  localparam int NB_PROD = NB_DATA + NB_EXP;
  localparam int NB_SUM  = NB_PROD + 1;
  localparam int SHIFT   = NB_EXP - 2;
  localparam int NB_SH   = NB_SUM - SHIFT;
  localparam logic [MW-1:0] M_LAST = MW'(NP - 1);
  localparam logic [PW-1:0] P_LAST = PW'(P - 1);
  localparam logic signed [NB_SUM-1:0] ROUND   = NB_SUM'(2 ** (SHIFT - 1));
  localparam logic [NB_OUT-1:0]        OUT_MAX = {1'b0, {(NB_OUT-1){1'b1}}};
  localparam logic [NB_OUT-1:0]        OUT_MIN = {1'b1, {(NB_OUT-1){1'b0}}};
  localparam logic signed [NB_SH-1:0]  SAT_MAX = NB_SH'(OUT_MAX);
  localparam logic signed [NB_SH-1:0]  SAT_MIN = ~SAT_MAX;

  logic accept, m_last;
  logic [MW-1:0] m_reg;
  logic [PW-1:0] p_reg;
  logic          frame_err_reg;

  assign accept = i_enable & i_fft_tvalid;
  assign m_last = (m_reg == M_LAST);

  // An early tlast closes the block: m resyncs to 0 and p advances as on a normal wrap
  always_ff @(posedge clock) begin
    if (i_reset) begin
      m_reg         <= '0;
      p_reg         <= '0;
      frame_err_reg <= 1'b0;
    end else if (accept) begin
      if (i_fft_tlast ^ m_last) frame_err_reg <= 1'b1;
      if (i_fft_tlast | m_last) begin
        m_reg <= '0;
        p_reg <= (p_reg == P_LAST) ? '0 : p_reg + PW'(1);
      end else begin
        m_reg <= m_reg + MW'(1);
      end
    end
  end

  logic                      valid0_reg, tlast0_reg;
  logic [MW-1:0]             m0_reg;
  logic [PW-1:0]             p0_reg;
  logic signed [NB_DATA-1:0] ar0_reg, ai0_reg;

  always_ff @(posedge clock) begin
    if (i_reset) begin
      valid0_reg <= 1'b0;
      tlast0_reg <= 1'b0;
      m0_reg     <= '0;
      p0_reg     <= '0;
      ar0_reg    <= '0;
      ai0_reg    <= '0;
    end else begin
      valid0_reg <= accept;
      if (accept) begin
        tlast0_reg <= m_last;
        m0_reg     <= m_reg;
        p0_reg     <= p_reg;
        ar0_reg    <= i_fft_real;
        ai0_reg    <= i_fft_imag;
      end
    end
  end

  // The LUT coefficient for the sample held in stage 0 is presented on i_exp_* this cycle
  logic                      valid1_reg, tlast1_reg;
  logic [MW-1:0]             m1_reg;
  logic [PW-1:0]             p1_reg;
  logic signed [NB_PROD-1:0] prr_reg, pii_reg, pri_reg, pir_reg;

  always_ff @(posedge clock) begin
    if (i_reset) begin
      valid1_reg <= 1'b0;
      tlast1_reg <= 1'b0;
      m1_reg     <= '0;
      p1_reg     <= '0;
      prr_reg    <= '0;
      pii_reg    <= '0;
      pri_reg    <= '0;
      pir_reg    <= '0;
    end else begin
      valid1_reg <= valid0_reg;
      if (valid0_reg) begin
        tlast1_reg <= tlast0_reg;
        m1_reg     <= m0_reg;
        p1_reg     <= p0_reg;
        prr_reg    <= NB_PROD'(ar0_reg) * NB_PROD'(i_exp_real);
        pii_reg    <= NB_PROD'(ai0_reg) * NB_PROD'(i_exp_imag);
        pri_reg    <= NB_PROD'(ar0_reg) * NB_PROD'(i_exp_imag);
        pir_reg    <= NB_PROD'(ai0_reg) * NB_PROD'(i_exp_real);
      end
    end
  end

  logic                     valid2_reg, tlast2_reg;
  logic [MW-1:0]            m2_reg;
  logic [PW-1:0]            p2_reg;
  logic signed [NB_SUM-1:0] re_reg, im_reg;

  always_ff @(posedge clock) begin
    if (i_reset) begin
      valid2_reg <= 1'b0;
      tlast2_reg <= 1'b0;
      m2_reg     <= '0;
      p2_reg     <= '0;
      re_reg     <= '0;
      im_reg     <= '0;
    end else begin
      valid2_reg <= valid1_reg;
      if (valid1_reg) begin
        tlast2_reg <= tlast1_reg;
        m2_reg     <= m1_reg;
        p2_reg     <= p1_reg;
        re_reg     <= NB_SUM'(prr_reg) - NB_SUM'(pii_reg);
        im_reg     <= NB_SUM'(pri_reg) + NB_SUM'(pir_reg);
      end
    end
  end

  function automatic logic [NB_OUT:0] saturate(input logic signed [NB_SH-1:0] x);
    if (x > SAT_MAX) return {1'b1, OUT_MAX};
    if (x < SAT_MIN) return {1'b1, OUT_MIN};
    return {1'b0, x[NB_OUT-1:0]};
  endfunction

  // Round half up in Q2.8 then drop the fraction; arithmetic shift keeps sign
  logic signed [NB_SUM-1:0] re_rnd, im_rnd;
  logic signed [NB_SH-1:0]  re_sh, im_sh;
  logic [NB_OUT:0]          re_sat, im_sat;

  assign re_rnd = re_reg + ROUND;
  assign im_rnd = im_reg + ROUND;
  assign re_sh  = NB_SH'(re_rnd >>> SHIFT);
  assign im_sh  = NB_SH'(im_rnd >>> SHIFT);
  assign re_sat = saturate(re_sh);
  assign im_sat = saturate(im_sh);

  logic sat_reg;

  always_ff @(posedge clock) begin
    if (i_reset) begin
      o_tvalid     <= 1'b0;
      o_tlast      <= 1'b0;
      o_prod_real  <= '0;
      o_prod_imag  <= '0;
      o_sample_idx <= '0;
      o_block_idx  <= '0;
      sat_reg      <= 1'b0;
    end else begin
      o_tvalid <= valid2_reg;
      o_tlast  <= valid2_reg & tlast2_reg;
      if (valid2_reg) begin
        o_prod_real  <= re_sat[NB_OUT-1:0];
        o_prod_imag  <= im_sat[NB_OUT-1:0];
        o_sample_idx <= m2_reg;
        o_block_idx  <= p2_reg;
        if (re_sat[NB_OUT] | im_sat[NB_OUT]) sat_reg <= 1'b1;
      end
    end
  end

  assign o_frame_err = frame_err_reg;
  assign o_sat       = sat_reg;

endmodule

// File: tb/tb_cyclo_downconvert_mult.sv
// Bench for cyclo_downconvert_mult with NP=16, P=4: directed corner cases plus a randomized
// gapped stream checked against a plain-arithmetic complex-multiply and frame-counting model.
module tb_cyclo_downconvert_mult;

  localparam int NP = 16;
  localparam int P  = 4;

  logic clock = 1'b0;
  logic i_reset, i_enable, i_fft_tvalid, i_fft_tlast;
  logic signed [15:0] i_fft_real, i_fft_imag;
  logic signed [9:0]  i_exp_real, i_exp_imag;
  logic signed [15:0] o_prod_real, o_prod_imag;
  logic o_tvalid, o_tlast, o_frame_err, o_sat;
  logic [3:0] o_sample_idx;
  logic [1:0] o_block_idx;

  cyclo_downconvert_mult #(.P(P), .NP(NP), .NB_DATA(16), .NB_EXP(10), .NB_OUT(16)) dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable),
    .i_fft_real(i_fft_real), .i_fft_imag(i_fft_imag),
    .i_fft_tvalid(i_fft_tvalid), .i_fft_tlast(i_fft_tlast),
    .i_exp_real(i_exp_real), .i_exp_imag(i_exp_imag),
    .o_prod_real(o_prod_real), .o_prod_imag(o_prod_imag),
    .o_tvalid(o_tvalid), .o_tlast(o_tlast),
    .o_sample_idx(o_sample_idx), .o_block_idx(o_block_idx),
    .o_frame_err(o_frame_err), .o_sat(o_sat)
  );

  always #5 clock = ~clock;

  typedef struct {
    int re; int im; bit tl; int m; int p; int cyc;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int stray_tlast = 0;
  int pend_r = 0, pend_i = 0;
  int mm = 0, pp = 0;
  bit m_ferr = 0, m_sat = 0;

  // One clock: data for this cycle, coefficient of the previous cycle's sample, then observe
  task automatic clk_cycle(input bit en, input bit v, input bit tl,
                           input int dr, input int di, input int cr, input int ci);
    rec_t r;
    i_enable     = en;
    i_fft_tvalid = v;
    i_fft_tlast  = tl;
    i_fft_real   = 16'(dr);
    i_fft_imag   = 16'(di);
    i_exp_real   = 10'(pend_r);
    i_exp_imag   = 10'(pend_i);
    pend_r = cr;
    pend_i = ci;
    @(posedge clock);
    #1;
    cyc++;
    if (o_tvalid) begin
      r.re = int'(o_prod_real); r.im = int'(o_prod_imag); r.tl = o_tlast;
      r.m = int'(o_sample_idx); r.p = int'(o_block_idx); r.cyc = cyc;
      obs_q.push_back(r);
    end else if (o_tlast) begin
      stray_tlast++;
    end
  endtask

  function automatic int clamp16(input int x, inout bit s);
    if (x > 32767) begin s = 1; return 32767; end
    if (x < -32768) begin s = 1; return -32768; end
    return x;
  endfunction

  // Reference: complex product in Q2.8, round half up, clamp; counters follow frame rules
  task automatic send(input bit en, input bit v, input bit tl,
                      input int dr, input int di, input int cr, input int ci);
    rec_t e;
    if (en && v) begin
      e.re  = clamp16((dr * cr - di * ci + 128) >>> 8, m_sat);
      e.im  = clamp16((dr * ci + di * cr + 128) >>> 8, m_sat);
      e.m   = mm;
      e.p   = pp;
      e.tl  = (mm == NP - 1);
      e.cyc = cyc + 1 + 3;
      exp_q.push_back(e);
      if (tl != (mm == NP - 1)) m_ferr = 1;
      if (tl || mm == NP - 1) begin
        mm = 0;
        pp = (pp + 1) % P;
      end else begin
        mm++;
      end
    end
    clk_cycle(en, v, tl, dr, di, cr, ci);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) clk_cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    idle(2);
    i_reset = 1'b0;
    exp_q.delete(); obs_q.delete();
    mm = 0; pp = 0; m_ferr = 0; m_sat = 0; stray_tlast = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (o_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid got %0b want 0", o_tvalid); end
    vectors++; if (o_tlast !== 1'b0) begin miscompares++; $display("FAIL reset_tlast got %0b want 0", o_tlast); end
    vectors++; if (o_prod_real !== 16'sd0 || o_prod_imag !== 16'sd0) begin miscompares++; $display("FAIL reset_data got (%0d,%0d) want (0,0)", o_prod_real, o_prod_imag); end
    vectors++; if (o_sample_idx !== 4'd0 || o_block_idx !== 2'd0) begin miscompares++; $display("FAIL reset_idx got m=%0d p=%0d want 0,0", o_sample_idx, o_block_idx); end
    vectors++; if (o_frame_err !== 1'b0 || o_sat !== 1'b0) begin miscompares++; $display("FAIL reset_flags got ferr=%0b sat=%0b want 0,0", o_frame_err, o_sat); end
    $display("test_reset done");
  endtask

  task automatic test_unity();
    int acc;
    do_reset();
    acc = cyc + 1;
    send(1, 1, 0, 1000, -500, 256, 0);
    idle(6);
    vectors++; if (obs_q.size() !== 1) begin miscompares++; $display("FAIL unity_count got %0d want 1", obs_q.size()); end
    else begin
      vectors++; if (obs_q[0].re !== 1000 || obs_q[0].im !== -500) begin miscompares++; $display("FAIL unity_data got (%0d,%0d) want (1000,-500)", obs_q[0].re, obs_q[0].im); end
      vectors++; if (obs_q[0].cyc !== acc + 3) begin miscompares++; $display("FAIL unity_latency got edge %0d want edge %0d", obs_q[0].cyc - acc + 1, 4); end
      vectors++; if (obs_q[0].m !== 0 || obs_q[0].p !== 0) begin miscompares++; $display("FAIL unity_idx got m=%0d p=%0d want 0,0", obs_q[0].m, obs_q[0].p); end
    end
    $display("test_unity: %0d outputs", obs_q.size());
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(1, 1, 0, 100, 200, 0, 256);
    send(1, 1, 0, 1000, 0, 181, 181);
    idle(6);
    vectors++; if (obs_q.size() !== 2) begin miscompares++; $display("FAIL b2b_count got %0d want 2", obs_q.size()); end
    else begin
      vectors++; if (obs_q[0].re !== -200 || obs_q[0].im !== 100) begin miscompares++; $display("FAIL b2b_plus_j got (%0d,%0d) want (-200,100)", obs_q[0].re, obs_q[0].im); end
      vectors++; if (obs_q[1].re !== 707 || obs_q[1].im !== 707) begin miscompares++; $display("FAIL b2b_round got (%0d,%0d) want (707,707)", obs_q[1].re, obs_q[1].im); end
      vectors++; if (obs_q[1].cyc !== obs_q[0].cyc + 1 || obs_q[1].m !== 1) begin miscompares++; $display("FAIL b2b_seq got cyc_delta=%0d m=%0d want 1,1", obs_q[1].cyc - obs_q[0].cyc, obs_q[1].m); end
    end
    vectors++; if (o_sat !== 1'b0) begin miscompares++; $display("FAIL b2b_nosat got %0b want 0", o_sat); end
    $display("test_back_to_back: %0d outputs", obs_q.size());
  endtask

  task automatic test_saturation();
    do_reset();
    send(1, 1, 0, 32767, 32767, 256, 256);
    send(1, 1, 0, -32768, 0, -256, 0);
    idle(6);
    vectors++; if (obs_q.size() !== 2) begin miscompares++; $display("FAIL sat_count got %0d want 2", obs_q.size()); end
    else begin
      vectors++; if (obs_q[0].re !== 0 || obs_q[0].im !== 32767) begin miscompares++; $display("FAIL sat_fullscale got (%0d,%0d) want (0,32767)", obs_q[0].re, obs_q[0].im); end
      vectors++; if (obs_q[1].re !== 32767 || obs_q[1].im !== 0) begin miscompares++; $display("FAIL sat_neg1sq got (%0d,%0d) want (32767,0)", obs_q[1].re, obs_q[1].im); end
    end
    vectors++; if (o_sat !== 1'b1) begin miscompares++; $display("FAIL sat_flag got %0b want 1", o_sat); end
    vectors++; if (o_frame_err !== 1'b0) begin miscompares++; $display("FAIL sat_ferr got %0b want 0", o_frame_err); end
    $display("test_saturation: %0d outputs", obs_q.size());
  endtask

  task automatic test_random_gaps();
    int n = 0;
    int bad = 0;
    do_reset();
    while (n < 70) begin
      int r = $urandom_range(0, 3);
      int dr = $urandom_range(0, 65535) - 32768;
      int di = $urandom_range(0, 65535) - 32768;
      int cr = $urandom_range(0, 1023) - 512;
      int ci = $urandom_range(0, 1023) - 512;
      if (r == 0) send(1, 0, 1'($urandom_range(0, 1)), dr, di, cr, ci);
      else if (r == 1) send(0, 1, 1'($urandom_range(0, 1)), dr, di, cr, ci);
      else begin
        send(1, 1, (mm == NP - 1), dr, di, cr, ci);
        n++;
      end
    end
    idle(6);
    vectors++; if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (obs_q[i].re !== exp_q[i].re || obs_q[i].im !== exp_q[i].im || obs_q[i].tl !== exp_q[i].tl ||
            obs_q[i].m !== exp_q[i].m || obs_q[i].p !== exp_q[i].p || obs_q[i].cyc !== exp_q[i].cyc) begin
          miscompares++; bad++;
          $display("FAIL rand_sample[%0d] got (%0d,%0d) tl=%0b m=%0d p=%0d cyc=%0d want (%0d,%0d) tl=%0b m=%0d p=%0d cyc=%0d",
                   i, obs_q[i].re, obs_q[i].im, obs_q[i].tl, obs_q[i].m, obs_q[i].p, obs_q[i].cyc,
                   exp_q[i].re, exp_q[i].im, exp_q[i].tl, exp_q[i].m, exp_q[i].p, exp_q[i].cyc);
        end
      end
    end
    vectors++; if (o_frame_err !== 1'b0) begin miscompares++; $display("FAIL rand_ferr got %0b want 0", o_frame_err); end
    vectors++; if (o_sat !== m_sat) begin miscompares++; $display("FAIL rand_sat got %0b want %0b", o_sat, m_sat); end
    vectors++; if (stray_tlast !== 0) begin miscompares++; $display("FAIL rand_stray_tlast got %0d want 0", stray_tlast); end
    $display("test_random_gaps: %0d samples, %0d bad", exp_q.size(), bad);
  endtask

  task automatic test_frame_err();
    do_reset();
    for (int i = 0; i < 9; i++) send(1, 1, 0, 10 * i, -i, 256, 0);
    send(1, 1, 1, 90, -9, 256, 0);
    send(1, 1, 0, 1234, 0, 256, 0);
    idle(6);
    vectors++; if (o_frame_err !== 1'b1) begin miscompares++; $display("FAIL ferr_flag got %0b want 1", o_frame_err); end
    vectors++; if (obs_q.size() !== 11) begin miscompares++; $display("FAIL ferr_count got %0d want 11", obs_q.size()); end
    else begin
      vectors++; if (obs_q[9].m !== 9 || obs_q[9].tl !== 1'b0) begin miscompares++; $display("FAIL ferr_early got m=%0d tl=%0b want 9,0", obs_q[9].m, obs_q[9].tl); end
      vectors++; if (obs_q[10].m !== 0 || obs_q[10].p !== 1 || obs_q[10].re !== 1234) begin miscompares++; $display("FAIL ferr_resync got m=%0d p=%0d re=%0d want 0,1,1234", obs_q[10].m, obs_q[10].p, obs_q[10].re); end
    end
    $display("test_frame_err: %0d outputs", obs_q.size());
  endtask

  task automatic test_reset_inflight();
    send(1, 1, 0, 32767, 32767, 256, 256);
    idle(6);
    vectors++; if (o_sat !== 1'b1 || o_frame_err !== 1'b1) begin miscompares++; $display("FAIL inflight_pre got sat=%0b ferr=%0b want 1,1", o_sat, o_frame_err); end
    obs_q.delete();
    send(1, 1, 0, 1, 2, 256, 0);
    send(1, 1, 0, 3, 4, 256, 0);
    send(1, 1, 0, 5, 6, 256, 0);
    i_reset = 1'b1;
    idle(1);
    i_reset = 1'b0;
    idle(6);
    vectors++; if (obs_q.size() !== 0) begin miscompares++; $display("FAIL inflight_dropped got %0d outputs want 0", obs_q.size()); end
    vectors++; if (o_sat !== 1'b0 || o_frame_err !== 1'b0) begin miscompares++; $display("FAIL inflight_flags got sat=%0b ferr=%0b want 0,0", o_sat, o_frame_err); end
    vectors++; if (o_sample_idx !== 4'd0 || o_block_idx !== 2'd0) begin miscompares++; $display("FAIL inflight_idx got m=%0d p=%0d want 0,0", o_sample_idx, o_block_idx); end
    send(1, 1, 0, 77, 0, 256, 0);
    idle(6);
    vectors++; if (obs_q.size() !== 1 || obs_q[0].m !== 0 || obs_q[0].p !== 0 || obs_q[0].re !== 77) begin
      miscompares++; $display("FAIL inflight_restart got %0d outputs (first m=%0d p=%0d re=%0d) want 1 output m=0 p=0 re=77",
                              obs_q.size(), obs_q.size() > 0 ? obs_q[0].m : -1, obs_q.size() > 0 ? obs_q[0].p : -1, obs_q.size() > 0 ? obs_q[0].re : -1);
    end
    $display("test_reset_inflight done");
  endtask

  initial begin
    i_reset = 1'b1; i_enable = 1'b0; i_fft_tvalid = 1'b0; i_fft_tlast = 1'b0;
    i_fft_real = '0; i_fft_imag = '0; i_exp_real = '0; i_exp_imag = '0;
    test_reset();
    test_unity();
    test_back_to_back();
    test_saturation();
    test_random_gaps();
    test_frame_err();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
